// File: rtl/rv32_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32_mem_arbiter_if
// Description : Fetch, load/store and memory bus signals of the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32_mem_arbiter_if;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;

  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  logic        spurious_rsp;

  // Environment side: requesters and memory.
  modport master (
    output if_req_valid, if_req_addr,
    input  if_rsp_valid, if_rsp_data,
    output d_req_valid, d_req_addr, d_req_wdata, d_req_wstrb,
    input  d_rsp_valid, d_rsp_data,
    input  mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  spurious_rsp
  );

  // Arbiter side.
  modport slave (
    input  if_req_valid, if_req_addr,
    output if_rsp_valid, if_rsp_data,
    input  d_req_valid, d_req_addr, d_req_wdata, d_req_wstrb,
    output d_rsp_valid, d_rsp_data,
    output mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output spurious_rsp
  );
endinterface
`default_nettype wire

// File: rtl/rv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32_mem_arbiter
// Description : Fetch vs load/store arbiter for a single-ported memory, one
//               outstanding transaction, data priority with starvation bound.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  rv32_mem_arbiter_if.slave bus
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_BUSY   = 1'b1;
  localparam logic       c_OWN_IF = 1'b0;
  localparam logic       c_OWN_D  = 1'b1;
  localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

  logic [0:0] r_state;
  logic       r_owner;
  logic [3:0] r_starve_cnt;
  logic       r_spurious;

  logic w_grant_d;
  logic w_grant_if;
  logic w_handshake;
  logic w_rsp;

  always_comb begin
    w_grant_d  = 1'b0;
    w_grant_if = 1'b0;
    if (r_state == S_IDLE) begin
      if (bus.d_req_valid && bus.if_req_valid) begin
        if (r_starve_cnt < c_STARVE_LIMIT) begin
          w_grant_d = 1'b1;
        end else begin
          w_grant_if = 1'b1;
        end
      end else begin
        w_grant_d  = bus.d_req_valid;
        w_grant_if = bus.if_req_valid;
      end
    end
  end

  assign bus.mem_req_valid = w_grant_d | w_grant_if;
  assign bus.mem_req_addr  = w_grant_d  ? bus.d_req_addr  :
                             w_grant_if ? bus.if_req_addr : 32'h0;
  assign bus.mem_req_wdata = w_grant_d  ? bus.d_req_wdata : 32'h0;
  assign bus.mem_req_wstrb = w_grant_d  ? bus.d_req_wstrb : 4'h0;

  assign w_handshake = bus.mem_req_valid && bus.mem_req_ready;

  // Responses are routed combinationally to whichever port owns the transaction.
  assign w_rsp            = (r_state == S_BUSY) && bus.mem_rsp_valid;
  assign bus.if_rsp_valid = w_rsp && (r_owner == c_OWN_IF);
  assign bus.d_rsp_valid  = w_rsp && (r_owner == c_OWN_D);
  assign bus.if_rsp_data  = bus.mem_rsp_data;
  assign bus.d_rsp_data   = bus.mem_rsp_data;
  assign bus.spurious_rsp = r_spurious;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_owner      <= c_OWN_IF;
      r_starve_cnt <= 4'd0;
      r_spurious   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (bus.mem_rsp_valid) begin
        r_spurious <= 1'b1;
      end
      if (w_handshake) begin
        r_state <= S_BUSY;
        r_owner <= w_grant_d ? c_OWN_D : c_OWN_IF;
        // Only a data win over a waiting fetch counts towards starvation.
        if (w_grant_d && bus.if_req_valid) begin
          if (r_starve_cnt < c_STARVE_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
          end
        end else begin
          r_starve_cnt <= 4'd0;
        end
      end
    end else begin
      if (bus.mem_rsp_valid) begin
        r_state <= S_IDLE;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/rv32_mem_arbiter.md
# rv32_mem_arbiter

Two-requester arbiter that shares a single-ported, variable-latency data memory between instruction fetch and the memory stage's load/store unit. It sits between the core's two memory clients and the memory. It tracks exactly one outstanding transaction and routes each response back to the requester that owns it. Data accesses have priority over fetch, and a bounded starvation counter guarantees fetch forward progress.

## Interface
- STARVE_LIMIT, 4, max consecutive data grants won while fetch is waiting; range 1..15.

- clk  in  1  clock
- resetn  in  1  reset; resetn, synchronous, active-low; clock clk
- if_req_valid  in  1  fetch request pending; held until if_rsp_valid
- if_req_addr  in  32  fetch word address
- if_rsp_valid  out  1  one-cycle pulse, fetch response valid
- if_rsp_data  out  32  fetch read data, valid with if_rsp_valid
- d_req_valid  in  1  load/store request pending; held until d_rsp_valid
- d_req_addr  in  32  load/store address
- d_req_wdata  in  32  store data
- d_req_wstrb  in  4  byte write strobes; 0 = load
- d_rsp_valid  out  1  one-cycle pulse, data response valid
- d_rsp_data  out  32  load data, valid with d_rsp_valid
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request this cycle
- mem_req_addr  out  32  muxed address
- mem_req_wdata  out  32  muxed write data (0 for fetch)
- mem_req_wstrb  out  4  muxed strobes (0 for fetch)
- mem_rsp_valid  in  1  memory response; one pulse per accepted request, including writes
- mem_rsp_data  in  32  memory read data
- spurious_rsp  out  1  sticky: mem_rsp_valid seen while no transaction is outstanding

## Operation
- FSM states: IDLE, BUSY. Registers: state, owner (IF/D), starve_cnt (4 bits), spurious_rsp.
- IDLE, combinational grant:
  - d_req_valid only: grant D.
  - if_req_valid only: grant IF.
  - Both valid: grant D if starve_cnt < STARVE_LIMIT, else grant IF.
- mem_req_valid = grant exists, asserted in IDLE only. Address, wdata and wstrb come from the granted port. With no grant, all three are driven 0.
- Handshake mem_req_valid && mem_req_ready: go to BUSY, latch owner = granted port.
- Without mem_req_ready: stay in IDLE and re-arbitrate next cycle. The grant may change if inputs change, and the counter does not update.
- starve_cnt updates on each accepted handshake:
  - D granted while if_req_valid = 1: increment, saturating at STARVE_LIMIT.
  - IF granted, or D granted while if_req_valid = 0: clear to 0.
- BUSY: mem_req_valid = 0.
  - On mem_rsp_valid: if_rsp_valid or d_rsp_valid = mem_rsp_valid for the matching owner; the other port stays 0. Both *_rsp_data = mem_rsp_data (pass-through), and the next state is IDLE.
  - Otherwise remain in BUSY indefinitely; there is no timeout.
- mem_rsp_valid in IDLE: dropped, never forwarded; sets spurious_rsp to 1, cleared only by reset.
- Requester rule: a requester must not drop or change its request before its rsp_valid. Violations are undefined.

## Timing
- Reset: state = IDLE, owner = IF, starve_cnt = 0, spurious_rsp = 0. All *_rsp_valid = 0. mem_req_valid follows the IDLE grant logic from the first cycle after reset.
- Reset mid-transaction abandons the outstanding request. A late memory response then raises spurious_rsp.
- Request seen and accepted in cycle N (memory ready):
  - Earliest response is cycle N+1, delivered combinationally the same cycle as mem_rsp_valid.
  - The arbiter is back in IDLE at N+2, so its peak rate is 1 transaction per 2 cycles.
- A request arriving while BUSY waits in IDLE for arbitration. Its minimum wait is 1 cycle after the current response.
- With both ports continuously requesting and single-cycle memory, the grant sequence is D×STARVE_LIMIT then IF, repeating.

## Test plan
- Single fetch, addr 0x100, memory ready, response 0xDEADBEEF after 3 cycles:
  - mem_req_addr = 0x100 with wstrb = 0 in cycle 0.
  - if_rsp_valid pulse with 0xDEADBEEF in cycle 3; d_rsp_valid stays 0.
- Store, addr 0x2004, wdata 0x12345678, wstrb 0xF; memory holds mem_req_ready = 0 for 2 cycles:
  - Request held stable for 3 cycles.
  - d_rsp_valid pulses exactly once.
- Both requesting continuously, STARVE_LIMIT = 4, 1-cycle memory:
  - Grants are D,D,D,D,IF,D,D,D,D,IF.
  - starve_cnt returns to 0 after each IF grant.
- Fetch deasserted between data grants:
  - starve_cnt clears, so fetch is not favoured early.
- mem_rsp_valid pulsed in IDLE:
  - No *_rsp_valid output.
  - spurious_rsp = 1 and stays set until resetn = 0.
- resetn low while BUSY, then a late response:
  - All outputs reach reset values the next cycle.
  - The late response sets spurious_rsp.
